// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int unsigned SUB_WIDTH_DEF = 16;

endpackage

// File: rtl/fullAdder_1b.sv
// One-bit full adder cell: sum and carry of a + b + cin.
module fullAdder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_sub_16b.sv
// Bit-serial two's-complement subtractor computing A - B, LSB first.
// One full-adder cell is reused with B inverted and the carry seeded to 1.
// Optional macro SERIAL_SUB_OVF_EN adds the registered signed-overflow output Ovf.
module serial_sub_16b
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             s_bit, c_out;

  fullAdder_1b u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (c_q),
    .sum  (s_bit),
    .cout (c_out)
  );

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: accept in IDLE/DONE, one bit per cycle in SHIFT.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = A;
          sb_d    = ~B;
          c_d     = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        c_d   = c_out;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {s_bit, res_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH - 1)) begin
          // The last sum bit enters the result and Diff on the same edge.
          diff_d  = res_d;
          bout_d  = ~c_out;
          ovf_d   = c_q ^ c_out;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Diff = diff_q;
  assign Bout = bout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

`ifdef SERIAL_SUB_OVF_EN
  assign Ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_16b.sv
// Self-checking bench for serial_sub_16b with a behavioural arithmetic model.
module tb_serial_sub_16b;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         Ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_sub_16b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Diff  (Diff),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    return a - b;
  endfunction

  function automatic logic m_bout(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b);
  endfunction

  function automatic logic m_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W:0] r;
    r = $signed({a[W-1], a}) - $signed({b[W-1], b});
    return (r > $signed((W+1)'(2**(W-1) - 1))) || (r < -$signed((W+1)'(2**(W-1))));
  endfunction

  // Drive one start pulse; returns at 1 time unit after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({Diff, Bout, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got Diff=%h Bout=%b busy=%b done=%b, want all 0", Diff, Bout, busy, done);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (Ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", Ovf);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] av [3] = '{16'h0005, 16'h0003, 16'h8000};
    logic [W-1:0] bv [3] = '{16'h0003, 16'h0005, 16'h0001};
    logic [W-1:0] ed [3] = '{16'h0002, 16'hFFFE, 16'h7FFF};
    logic         eb [3] = '{1'b0, 1'b1, 1'b0};
    int n;
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i]);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_busy: got busy=%b done=%b want busy=1 done=0", i, busy, done);
      end
      wait_done(n);
      checks++;
      if (n != W || busy !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d cycles busy=%b want %0d busy=0", i, n, busy, W);
      end
      checks++;
      if (Diff !== ed[i] || Bout !== eb[i] || Diff !== m_diff(av[i], bv[i]) || Bout !== m_bout(av[i], bv[i])) begin
        errors++;
        $display("FAIL dir%0d_result: got Diff=%h Bout=%b want Diff=%h Bout=%b", i, Diff, Bout, ed[i], eb[i]);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (Ovf !== m_ovf(av[i], bv[i]) || Ovf !== (i == 2)) begin
        errors++;
        $display("FAIL dir%0d_ovf: got %b want %b", i, Ovf, m_ovf(av[i], bv[i]));
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || Diff !== ed[i]) begin
        errors++;
        $display("FAIL dir%0d_hold: got done=%b Diff=%h want done=0 Diff=%h", i, done, Diff, ed[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(16'h1234, 16'h0034);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      n = k;
      if (k == 4) begin
        start = 1'b1; A = 16'hAAAA; B = 16'h1111;
      end
      if (k == 5) start = 1'b0;
      if (done) break;
    end
    checks++;
    if (n != W || Diff !== 16'h1200 || Bout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got n=%0d Diff=%h Bout=%b want n=%0d Diff=1200 Bout=0", n, Diff, Bout, W);
    end
    issue(16'hFFFF, 16'hFFFF);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy);
    end
    wait_done(n);
    checks++;
    if (n != W || Diff !== 16'h0000 || Bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: got n=%0d Diff=%h Bout=%b want n=%0d Diff=0000 Bout=0", n, Diff, Bout, W);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (Ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ovf: got %b want 0", Ovf);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [W:0]   ref_sum;
    int n;
    for (int i = 0; i < 500; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 7 == 0) b = a;
      issue(a, b);
      wait_done(n);
      ref_sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      checks++;
      if (n != W || {~Bout, Diff} !== ref_sum) begin
        errors++;
        $display("FAIL rand%0d ERRORCHECK: A=%h B=%h got n=%0d {~Bout,Diff}=%h want n=%0d %h",
                 i, a, b, n, {~Bout, Diff}, W, ref_sum);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (Ovf !== m_ovf(a, b)) begin
        errors++;
        $display("FAIL rand%0d_ovf: A=%h B=%h got %b want %b", i, a, b, Ovf, m_ovf(a, b));
      end
`endif
      if (i % 3 == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int bad = 0;
    issue(16'h0005, 16'h0003);
    wait_done(n);
    issue(16'h4000, 16'h0001);
    repeat (8) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({Diff, Bout, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got Diff=%h Bout=%b busy=%b done=%b want all 0", Diff, Bout, busy, done);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (Ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ovf: got %b want 0", Ovf);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || Diff !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_after: got %0d cycles with activity want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
